axi4l_if_regs: RTL and testbench
================================

Name: axi4l_if_regs

Overview:
- AXI4-Lite slave endpoint with a small memory-mapped register bank; the bus-facing end of the axi4l_if interface.
- Sits between a system AXI4-Lite master (CPU or BFM) and fabric control/status signals.
- Supports independent read and write channels, one outstanding transaction per direction.

Parameters:
- ADDR_WIDTH, 32, AXI address width; only bits [3:2] are decoded and bits [1:0] are ignored.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ID_VALUE, 32'h4158_4C31, constant returned by the ID register.

Ports:
- axi4l_aclk  in  1  AXI clock; all logic is on its rising edge.
- axi4l_arstn  in  1  reset, asynchronous, active-high.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  ignored.
- awvalid  in  1  / awready  out  1: write address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1  / wready  out  1: write data handshake.
- bresp  out  2  / bvalid  out  1  / bready  in  1: write response channel.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  ignored.
- arvalid  in  1  / arready  out  1: read address handshake.
- rdata  out  DATA_WIDTH  / rresp  out  2  / rvalid  out  1  / rready  in  1: read data channel.
- ctrl_o  out  DATA_WIDTH  current CTRL register value.
- status_i  in  DATA_WIDTH  status input, already synchronous to axi4l_aclk.

Behaviour:
- Register map (offset, access, reset value):
  - 0x00 ID, RO, ID_VALUE.
  - 0x04 SCRATCH, RW, 0.
  - 0x08 CTRL, RW, 0; drives ctrl_o directly.
  - 0x0C STATUS, RO; returns status_i sampled at the AR handshake edge.
  - Addresses above 0x0C alias modulo 16.
- Reset state (axi4l_arstn=1), asynchronous:
  - awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, SCRATCH=CTRL=0.
  - Pending transactions are discarded. Reset asserted mid-transaction aborts it with no register update.
- After reset deasserts: awready=wready=arready=1 from the first rising edge.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle, into one-entry holding registers.
  - awready drops while the AW holder is full; wready drops while the W holder is full.
  - Once both holders are full, the register is updated at the next edge and bvalid rises at that same edge.
  - Latency: bvalid is 1 cycle after the later of the two handshakes.
  - bvalid stays high until bready. Holders clear on the B handshake, and awready/wready return to 1 the next cycle.
  - Writes to ID or STATUS: no effect, bresp=SLVERR (2'b10). Otherwise bresp=OKAY (2'b00).
- Read path:
  - AR handshake happens when arvalid&&arready.
  - rdata/rresp are registered on that edge, so rvalid rises at the next edge (1-cycle latency).
  - arready=0 while rvalid=1.
  - rdata, rresp and rvalid stay stable until rready. arready returns to 1 the cycle after the R handshake.
  - All reads return rresp=OKAY.
- Simultaneous read and write of the same register: the read returns the pre-write value.
- Outputs hold steady under backpressure, with no combinational paths from valid to ready.

Optional Feature:
- Macro: AXI4L_IF_WSTRB_EN.
- Defined: only bytes with wstrb[i]=1 are updated; wstrb=0 is an OKAY response with no change.
- Undefined: wstrb is ignored and every write updates the full 32-bit word.

Decomposition:
- Shared package axi4l_pkg holds:
  - resp typedef enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - register offset localparams (ID_OFS, SCRATCH_OFS, CTRL_OFS, STATUS_OFS);
  - the default ID constant.
- One sub-module, axi4l_if_regfile: write port with byte enables, combinational read mux, CTRL output.
- The top level holds the AXI handshake logic.

Test Plan:
- Reset held 10 cycles, then read 0x0 -> rvalid exactly 1 cycle after the AR handshake, rdata=32'h4158_4C31, rresp=OKAY.
- Write 0x4 with 32'hDEAD_BEEF (AW and W in the same cycle), then read 0x4 -> bresp=OKAY, rdata=32'hDEAD_BEEF.
- W presented 3 cycles before AW to CTRL with 32'h0000_00A5 -> wready low after the W handshake, bvalid 1 cycle after the AW handshake, ctrl_o=32'hA5.
- Write to 0x0 with 32'h1234_5678 -> bresp=SLVERR; a subsequent read still returns ID_VALUE.
- Hold rready=0 for 5 cycles after reading STATUS with status_i=32'h55 -> rvalid and rdata=32'h55 held stable and arready=0 until the R handshake.
- With AXI4L_IF_WSTRB_EN: SCRATCH=32'hFFFF_FFFF, write 32'h0 with wstrb=4'b0101 -> readback 32'hFF00_FF00. Without the macro the same write reads back 32'h0.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes, register offsets, default ID word.
// Also provides the byte-enable merge used by the register file write port.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [3:0]  ID_OFS      = 4'h0;
    localparam logic [3:0]  SCRATCH_OFS = 4'h4;
    localparam logic [3:0]  CTRL_OFS    = 4'h8;
    localparam logic [3:0]  STATUS_OFS  = 4'hC;

    localparam logic [31:0] ID_DEFAULT  = 32'h4158_4C31;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4l_if_regfile.sv
// ID/SCRATCH/CTRL/STATUS register bank with byte-enable write port and combinational read mux.
// Byte strobes honoured only when AXI4L_IF_WSTRB_EN is defined; otherwise full-word writes.
import axi4l_pkg::*;

module axi4l_if_regfile #(
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  raddr,
    input  logic [31:0] status,
    output logic [31:0] rdata,
    output logic        wr_err,
    output logic [31:0] ctrl
);

    logic [31:0] scratch;
    logic [3:0]  be;

`ifdef AXI4L_IF_WSTRB_EN
    assign be = wstrb;
`else
    logic unused_strb;
    assign unused_strb = ^wstrb;
    assign be = 4'hF;
`endif

    // ID and STATUS are read-only; writes to them are refused with an error response.
    assign wr_err = (waddr[3:2] == ID_OFS[3:2]) || (waddr[3:2] == STATUS_OFS[3:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= '0;
            ctrl    <= '0;
        end else if (we && !wr_err) begin
            if (waddr[3:2] == SCRATCH_OFS[3:2]) scratch <= merge_bytes(scratch, wdata, be);
            if (waddr[3:2] == CTRL_OFS[3:2])    ctrl    <= merge_bytes(ctrl, wdata, be);
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr[3:2])
            ID_OFS[3:2]:      rdata = ID_VALUE;
            SCRATCH_OFS[3:2]: rdata = scratch;
            CTRL_OFS[3:2]:    rdata = ctrl;
            default:          rdata = status;
        endcase
    end

endmodule

// File: rtl/axi4l_if_regs.sv
// AXI4-Lite slave endpoint: one-entry AW/W holders, registered B and R channels, 1-cycle latency.
// Optional byte strobes via AXI4L_IF_WSTRB_EN; readies derived only from registered state.
import axi4l_pkg::*;

module axi4l_if_regs #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic                    axi4l_aclk,
    input  logic                    axi4l_arstn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   ctrl_o,
    input  logic [DATA_WIDTH-1:0]   status_i
);

    logic        up;
    logic        aw_full, w_full;
    logic [3:0]  aw_addr_q;
    logic [31:0] w_dat_q;
    logic [3:0]  w_strb_q;
    logic        wr_err;
    logic [31:0] rd_mux;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, do_write;

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr[ADDR_WIDTH-1:4], awaddr[1:0],
                         araddr[ADDR_WIDTH-1:4], araddr[1:0]};

    // 'up' keeps all readies low during reset and raises them from the first edge after.
    assign awready  = up && !aw_full;
    assign wready   = up && !w_full;
    assign arready  = up && !rvalid;

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign ar_hs    = arvalid && arready;
    assign b_hs     = bvalid && bready;
    assign r_hs     = rvalid && rready;
    assign do_write = aw_full && w_full && !bvalid;

    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            up        <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= OKAY;
        end else begin
            up <= 1'b1;
            if (b_hs) begin
                bvalid  <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= awaddr[3:0];
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_dat_q  <= wdata;
                    w_strb_q <= wstrb;
                end
                if (do_write) begin
                    bvalid <= 1'b1;
                    bresp  <= wr_err ? SLVERR : OKAY;
                end
            end
        end
    end

    // Read data is captured at the AR edge, so STATUS reflects status_i at that edge
    // and a same-edge write is not yet visible.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
        if (axi4l_arstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
            rresp  <= OKAY;
        end else if (r_hs) begin
            rvalid <= 1'b0;
        end
    end

    axi4l_if_regfile #(
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk    (axi4l_aclk),
        .rst    (axi4l_arstn),
        .we     (do_write),
        .waddr  (aw_addr_q),
        .wdata  (w_dat_q),
        .wstrb  (w_strb_q),
        .raddr  (araddr[3:0]),
        .status (status_i),
        .rdata  (rd_mux),
        .wr_err (wr_err),
        .ctrl   (ctrl_o)
    );

endmodule

// File: tb/tb_axi4l_if_regs.sv
// Directed bench for axi4l_if_regs with a register-array model and a per-cycle output compare.
module tb_axi4l_if_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, status_in = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg [4];
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_bresp = '0;
    logic        chk_en = 0;
    logic        wr_busy = 0;

    always #5 clk = ~clk;

    axi4l_if_regs dut (
        .axi4l_aclk (clk),      .axi4l_arstn (rst),
        .awaddr     (awaddr),   .awprot  (awprot),  .awvalid (awvalid), .awready (awready),
        .wdata      (wdata),    .wstrb   (wstrb),   .wvalid  (wvalid),  .wready  (wready),
        .bresp      (bresp),    .bvalid  (bvalid),  .bready  (bready),
        .araddr     (araddr),   .arprot  (arprot),  .arvalid (arvalid), .arready (arready),
        .rdata      (rdata),    .rresp   (rresp),   .rvalid  (rvalid),  .rready  (rready),
        .ctrl_o     (ctrl_o),   .status_i (status_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (rvalid) begin
                chk("cmp_rdata", rdata, exp_rdata);
                chk("cmp_rresp", {30'd0, rresp}, 32'd0);
            end
            if (bvalid) chk("cmp_bresp", {30'd0, bresp}, {30'd0, exp_bresp});
            if (!wr_busy) chk("cmp_ctrl", ctrl_o, m_reg[2]);
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        logic [1:0] idx;
        idx = a[3:2];
        exp_bresp = (idx == 2'd0 || idx == 2'd3) ? 2'b10 : 2'b00;
        wr_busy = 1;
        resp = 2'bxx;
        @(posedge clk);
        fork
            begin
                int n = 0;
                logic hs = 0;
                repeat (aw_dly) @(posedge clk);
                #1 awaddr = a; awvalid = 1;
                while (!hs && n < 50) begin
                    @(negedge clk); hs = awready; @(posedge clk); n++;
                end
                #1 awvalid = 0;
                if (!hs) chk("aw_timeout", 32'd0, 32'd1);
                if (aw_dly < w_dly) begin
                    @(negedge clk); chk("awready_low_while_held", {31'd0, awready}, 32'd0);
                end
            end
            begin
                int n = 0;
                logic hs = 0;
                repeat (w_dly) @(posedge clk);
                #1 wdata = d; wstrb = s; wvalid = 1;
                while (!hs && n < 50) begin
                    @(negedge clk); hs = wready; @(posedge clk); n++;
                end
                #1 wvalid = 0;
                if (!hs) chk("w_timeout", 32'd0, 32'd1);
                if (w_dly < aw_dly) begin
                    @(negedge clk); chk("wready_low_while_held", {31'd0, wready}, 32'd0);
                end
            end
        join
        @(negedge clk);
        chk("b_not_early", {31'd0, bvalid}, 32'd0);
        chk("awready_full", {31'd0, awready}, 32'd0);
        chk("wready_full", {31'd0, wready}, 32'd0);
        @(negedge clk);
        chk("b_latency", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        @(negedge clk);
        chk("b_cleared", {31'd0, bvalid}, 32'd0);
        chk("awready_back", {31'd0, awready}, 32'd1);
        chk("wready_back", {31'd0, wready}, 32'd1);
        if (exp_bresp == 2'b00) begin
`ifdef AXI4L_IF_WSTRB_EN
            for (int i = 0; i < 4; i++) if (s[i]) m_reg[idx][8*i +: 8] = d[8*i +: 8];
`else
            m_reg[idx] = d;
`endif
        end
        wr_busy = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] rd);
        int n = 0;
        logic hs = 0;
        exp_rdata = (a[3:2] == 2'd3) ? status_in : m_reg[a[3:2]];
        @(posedge clk);
        #1 araddr = a; arvalid = 1; rready = (hold == 0);
        while (!hs && n < 50) begin
            @(negedge clk); hs = arready; @(posedge clk); n++;
        end
        #1 arvalid = 0;
        if (!hs) chk("ar_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("r_latency", {31'd0, rvalid}, 32'd1);
        chk("arready_low_rvalid", {31'd0, arready}, 32'd0);
        rd = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", {31'd0, rvalid}, 32'd1);
            chk("r_hold_data", rdata, rd);
            chk("r_hold_arready", {31'd0, arready}, 32'd0);
        end
        rready = 1;
        @(negedge clk);
        chk("r_cleared", {31'd0, rvalid}, 32'd0);
        chk("arready_back", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        m_reg[0] = 32'h4158_4C31;
        m_reg[1] = '0;
        m_reg[2] = '0;
        m_reg[3] = '0;

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_ctrl",    ctrl_o, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("up_awready", {31'd0, awready}, 32'd1);
        chk("up_wready",  {31'd0, wready},  32'd1);
        chk("up_arready", {31'd0, arready}, 32'd1);
        chk_en = 1;

        axi_read(32'h0, 0, rd);
        chk("id_read", rd, 32'h4158_4C31);

        axi_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        chk("scratch_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h4, 0, rd);
        chk("scratch_read", rd, 32'hDEAD_BEEF);

        axi_write(32'h8, 32'h0000_00A5, 4'hF, 3, 0, resp);
        chk("ctrl_out", ctrl_o, 32'h0000_00A5);

        axi_write(32'h0, 32'h1234_5678, 4'hF, 0, 0, resp);
        chk("id_write_slverr", {30'd0, resp}, 32'd2);
        axi_read(32'h0, 0, rd);
        chk("id_unchanged", rd, 32'h4158_4C31);

        status_in = 32'h55;
        axi_read(32'hC, 5, rd);
        chk("status_read", rd, 32'h55);

        axi_read(32'h18, 0, rd);
        chk("alias_read", rd, 32'h0000_00A5);

        axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
        axi_write(32'h4, 32'h0000_0000, 4'b0101, 0, 0, resp);
        axi_read(32'h4, 0, rd);
`ifdef AXI4L_IF_WSTRB_EN
        chk("wstrb_read", rd, 32'hFF00_FF00);
`else
        chk("wstrb_read", rd, 32'h0000_0000);
`endif

        axi_write(32'h8, 32'h0000_003C, 4'hF, 0, 2, resp);
        axi_read(32'h8, 0, rd);
        chk("aw_first_read", rd, 32'h0000_003C);

        @(posedge clk);
        #1 awaddr = 32'h4; wdata = 32'h0000_7777; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk);
        #1 awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk_en = 0;
        rst = 1;
        #1;
        chk("abort_bvalid", {31'd0, bvalid}, 32'd0);
        chk("abort_ctrl", ctrl_o, 32'd0);
        m_reg[1] = '0;
        m_reg[2] = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("abort_no_b", {31'd0, bvalid}, 32'd0);
        chk("abort_awready", {31'd0, awready}, 32'd1);
        chk_en = 1;
        axi_read(32'h4, 0, rd);
        chk("abort_scratch", rd, 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
